// File: rtl/cla_pkg.sv
// Shared types and the second-level lookahead function for the pipelined CLA adder.
// Carries are built as sums of products, so there is no ripple from group to group.
package cla_pkg;

    localparam int GROUP_W    = 4;
    localparam int MAX_GROUPS = 32;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Carry into group k+1 is the OR of each lower generate, ANDed with every propagate
    // above it, plus cin when all propagates up to k are set.
    function automatic logic [MAX_GROUPS:0] cla_carries(input gp_t [MAX_GROUPS-1:0] gp,
                                                        input logic cin);
        logic [MAX_GROUPS:0] c;
        logic term;
        logic prop;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < MAX_GROUPS; k++) begin
            term = 1'b0;
            prop = 1'b1;
            for (int j = k; j >= 0; j--) begin
                term = term | (prop & gp[j].g);
                prop = prop & gp[j].p;
            end
            c[k+1] = term | (prop & cin);
        end
        return c;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream bundle for pipelined_cla_adder.
// The ovf signal exists only when CLA_OVF_EN is defined.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef CLA_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef CLA_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/cla_group.sv
// One 4-bit lookahead group: produces p/g and group G/P from the operands (stage 1),
// and the group's sum bits from registered p/g plus its carry-in (stage 2).
module cla_group
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    output logic [GROUP_W-1:0] p,
    output logic [GROUP_W-1:0] g,
    output gp_t                grp,
    input  logic [GROUP_W-1:0] p_r,
    input  logic [GROUP_W-1:0] g_r,
    input  logic               c_in,
    output logic [GROUP_W-1:0] s
);

    logic c1;
    logic c2;
    logic c3;

    assign p = a ^ b;
    assign g = a & b;

    assign grp.g = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign grp.p = &p;

    // In-group carries are flattened two-level terms so the group adds no serial delay.
    assign c1 = g_r[0] | (p_r[0] & c_in);
    assign c2 = g_r[1] | (p_r[1] & g_r[0]) | (p_r[1] & p_r[0] & c_in);
    assign c3 = g_r[2] | (p_r[2] & g_r[1]) | (p_r[2] & p_r[1] & g_r[0])
              | (p_r[2] & p_r[1] & p_r[0] & c_in);

    assign s = p_r ^ {c3, c2, c1, c_in};

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides.
// Define CLA_OVF_EN to build the registered signed-overflow output (bus.ovf).
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);

    localparam int NG = WIDTH / GROUP;

    if (GROUP != GROUP_W) begin : g_bad_group
        $error("pipelined_cla_adder: GROUP must be %0d", GROUP_W);
    end
    if ((WIDTH % GROUP) != 0 || WIDTH < GROUP || NG >= MAX_GROUPS) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP and below %0d groups",
               MAX_GROUPS);
    end

    logic                     s1_valid;
    logic                     s1_cin;
    logic [WIDTH-1:0]         s1_p;
    logic [WIDTH-1:0]         s1_g;
    gp_t  [NG-1:0]            s1_gp;

    logic [WIDTH-1:0]         p_next;
    logic [WIDTH-1:0]         g_next;
    gp_t  [NG-1:0]            gp_next;
    logic [WIDTH-1:0]         sum_next;

    gp_t  [MAX_GROUPS-1:0]    gp_pad;
    logic [MAX_GROUPS:0]      c_all;
    logic [NG:0]              c_grp;
    logic [MAX_GROUPS-NG-1:0] c_pad_unused;

    logic                     out_valid_q;
    logic [WIDTH-1:0]         sum_q;
    logic                     cout_q;

    logic                     s1_en;
    logic                     s2_en;

    // Output register frees up on transfer; stage 1 can load whenever stage 2 can take its beat.
    assign s2_en = !out_valid_q || bus.out_ready;
    assign s1_en = !s1_valid || s2_en;

    assign bus.in_ready  = s1_en;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group u_grp (
            .a    (bus.a[k*GROUP_W +: GROUP_W]),
            .b    (bus.b[k*GROUP_W +: GROUP_W]),
            .p    (p_next[k*GROUP_W +: GROUP_W]),
            .g    (g_next[k*GROUP_W +: GROUP_W]),
            .grp  (gp_next[k]),
            .p_r  (s1_p[k*GROUP_W +: GROUP_W]),
            .g_r  (s1_g[k*GROUP_W +: GROUP_W]),
            .c_in (c_grp[k]),
            .s    (sum_next[k*GROUP_W +: GROUP_W])
        );
    end

    // Unused upper groups are zero so they neither generate nor propagate.
    always_comb begin
        gp_pad         = '0;
        gp_pad[NG-1:0] = s1_gp;
    end

    assign c_all        = cla_carries(gp_pad, s1_cin);
    assign c_grp        = c_all[NG:0];
    assign c_pad_unused = c_all[MAX_GROUPS:NG+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cin   <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gp    <= '0;
        end else if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_p   <= p_next;
                s1_g   <= g_next;
                s1_gp  <= gp_next;
                s1_cin <= bus.cin;
            end
        end
    end

`ifdef CLA_OVF_EN
    logic ovf_q;
    logic ovf_next;

    // Carry into the MSB is recovered from its sum and propagate bits.
    assign ovf_next = sum_next[WIDTH-1] ^ s1_p[WIDTH-1] ^ c_grp[NG];
    assign bus.ovf  = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                sum_q  <= sum_next;
                cout_q <= c_grp[NG];
                ovf_q  <= ovf_next;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                sum_q  <= sum_next;
                cout_q <= c_grp[NG];
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed steps on a 32-bit adder, then random streams on 8/32/64-bit adders.
// Overflow checks are included when CLA_OVF_EN is defined.
module tb_pipelined_cla_adder;

    localparam int NBEATS   = 10000;
    localparam int MAXCYC   = 60000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(8))  b8  ();
    pipelined_cla_adder_if #(.WIDTH(32)) b32 ();
    pipelined_cla_adder_if #(.WIDTH(64)) b64 ();

    pipelined_cla_adder #(.WIDTH(8),  .GROUP(4)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    pipelined_cla_adder #(.WIDTH(64), .GROUP(4)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    int checks = 0;
    int errors = 0;

    logic [65:0] q8[$];
    logic [65:0] q32[$];
    logic [65:0] q64[$];

    task automatic checkOutput(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic r);
        b32.in_valid  = v;
        b32.a         = a;
        b32.b         = b;
        b32.cin       = c;
        b32.out_ready = r;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // {ovf, cout, sum} of a w-bit add from plain arithmetic; sum sits in the low 64 bits.
    function automatic logic [65:0] refAdd(input int w, input logic [63:0] a,
                                           input logic [63:0] b, input logic cin);
        logic [64:0] full;
        logic [63:0] mask;
        logic [63:0] s;
        logic        co;
        logic        ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        full = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, cin};
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
`ifdef CLA_OVF_EN
        return {ov, co, s};
`else
        return {1'b0 & ov, co, s};
`endif
    endfunction

    function automatic logic [65:0] obs8();
`ifdef CLA_OVF_EN
        return {b8.ovf, b8.cout, 56'd0, b8.sum};
`else
        return {1'b0, b8.cout, 56'd0, b8.sum};
`endif
    endfunction

    function automatic logic [65:0] obs32();
`ifdef CLA_OVF_EN
        return {b32.ovf, b32.cout, 32'd0, b32.sum};
`else
        return {1'b0, b32.cout, 32'd0, b32.sum};
`endif
    endfunction

    function automatic logic [65:0] obs64();
`ifdef CLA_OVF_EN
        return {b64.ovf, b64.cout, b64.sum};
`else
        return {1'b0, b64.cout, b64.sum};
`endif
    endfunction

    initial begin
        int          accepted;
        int          cyc;
        int          sent8;
        int          sent32;
        int          sent64;
        logic [65:0] exp;
        logic [7:0]  ra8, rb8;
        logic [31:0] ra32, rb32;
        logic [63:0] ra64, rb64;
        logic        rc8, rc32, rc64;

        rst_n = 1'b0;
        b8.in_valid  = 1'b0; b8.a  = '0; b8.b  = '0; b8.cin  = 1'b0; b8.out_ready  = 1'b1;
        b64.in_valid = 1'b0; b64.a = '0; b64.b = '0; b64.cin = 1'b0; b64.out_ready = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        repeat (2) tick();

        checkOutput("reset_out_valid", 66'(b32.out_valid), 66'd0);
        checkOutput("reset_sum_cout", 66'({b32.cout, b32.sum}), 66'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("in_ready_after_reset", 66'(b32.in_ready), 66'd1);

        // Full carry chain
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("chain_not_yet_valid", 66'(b32.out_valid), 66'd0);
        tick();
        checkOutput("chain_result", 66'({b32.out_valid, b32.cout, b32.sum}),
                    66'({1'b1, 1'b1, 32'h0000_0000}));
        tick();
        checkOutput("chain_drained", 66'(b32.out_valid), 66'd0);

        // Back-to-back beats
        applyStimulus(1'b1, 32'd1, 32'd2, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'd3, 32'd4, 1'b0, 1'b1);
        tick();
        checkOutput("b2b_first", 66'({b32.out_valid, b32.cout, b32.sum}), 66'({2'b10, 32'd3}));
        applyStimulus(1'b1, 32'h0000_FFFF, 32'd1, 1'b0, 1'b1);
        tick();
        checkOutput("b2b_second", 66'({b32.out_valid, b32.cout, b32.sum}), 66'({2'b10, 32'd7}));
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        checkOutput("b2b_third", 66'({b32.out_valid, b32.cout, b32.sum}),
                    66'({2'b10, 32'h0001_0000}));
        tick();
        checkOutput("b2b_drained", 66'(b32.out_valid), 66'd0);

        // Stall with continuous input: only two beats fit
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'(100 + i), 32'd1, 1'b0, 1'b0);
            if (b32.in_ready) accepted++;
            if (i >= 2) checkOutput("stall_hold", 66'({b32.out_valid, b32.sum}), 66'({1'b1, 32'd101}));
            tick();
        end
        checkOutput("stall_accepted", 66'(accepted), 66'd2);
        applyStimulus(1'b1, 32'd200, 32'd1, 1'b0, 1'b0);
        checkOutput("stall_in_ready_low", 66'(b32.in_ready), 66'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("drain_first", 66'({b32.out_valid, b32.cout, b32.sum}), 66'({2'b10, 32'd101}));
        tick();
        checkOutput("drain_second", 66'({b32.out_valid, b32.cout, b32.sum}), 66'({2'b10, 32'd102}));
        tick();
        checkOutput("drain_empty", 66'(b32.out_valid), 66'd0);

        // Reset with two beats in flight
        applyStimulus(1'b1, 32'd10, 32'd20, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'd30, 32'd40, 1'b0, 1'b0);
        tick();
        checkOutput("inflight_before_reset", 66'({b32.out_valid, b32.sum}), 66'({1'b1, 32'd30}));
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 66'(b32.out_valid), 66'd0);
        checkOutput("midreset_sum_cout", 66'({b32.cout, b32.sum}), 66'd0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        checkOutput("postreset_no_stale", 66'(b32.out_valid), 66'd0);
        applyStimulus(1'b1, 32'd5, 32'd6, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("postreset_no_stale2", 66'(b32.out_valid), 66'd0);
        tick();
        checkOutput("postreset_first", 66'({b32.out_valid, b32.cout, b32.sum}), 66'({2'b10, 32'd11}));
        tick();
        checkOutput("postreset_drained", 66'(b32.out_valid), 66'd0);

`ifdef CLA_OVF_EN
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        tick();
        checkOutput("ovf_pos", 66'({b32.ovf, b32.cout, b32.sum}), 66'({2'b10, 32'h8000_0000}));
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        checkOutput("ovf_neg", 66'({b32.ovf, b32.cout, b32.sum}), 66'({2'b11, 32'h0000_0000}));
        tick();
`endif

        // Random streams on all three widths against the arithmetic model
        sent8  = 0;
        sent32 = 0;
        sent64 = 0;
        cyc    = 0;
        while (cyc < MAXCYC && !(sent8 == NBEATS && sent32 == NBEATS && sent64 == NBEATS &&
                                 q8.size() == 0 && q32.size() == 0 && q64.size() == 0)) begin
            ra8  = 8'($urandom);  rb8  = 8'($urandom);  rc8  = 1'($urandom_range(1));
            ra32 = $urandom;      rb32 = $urandom;      rc32 = 1'($urandom_range(1));
            ra64 = {$urandom, $urandom}; rb64 = {$urandom, $urandom}; rc64 = 1'($urandom_range(1));
            b8.in_valid   = (sent8  < NBEATS) && ($urandom_range(3) != 0);
            b8.a = ra8;   b8.b = rb8;   b8.cin = rc8;
            b8.out_ready  = ($urandom_range(3) != 0);
            b32.in_valid  = (sent32 < NBEATS) && ($urandom_range(3) != 0);
            b32.a = ra32; b32.b = rb32; b32.cin = rc32;
            b32.out_ready = ($urandom_range(3) != 0);
            b64.in_valid  = (sent64 < NBEATS) && ($urandom_range(3) != 0);
            b64.a = ra64; b64.b = rb64; b64.cin = rc64;
            b64.out_ready = ($urandom_range(3) != 0);
            #1;

            if (b8.out_valid && b8.out_ready) begin
                checkOutput("rand8_pending", 66'(q8.size() > 0), 66'd1);
                if (q8.size() > 0) begin
                    exp = q8.pop_front();
                    checkOutput("rand8_result", obs8(), exp);
                end
            end
            if (b32.out_valid && b32.out_ready) begin
                checkOutput("rand32_pending", 66'(q32.size() > 0), 66'd1);
                if (q32.size() > 0) begin
                    exp = q32.pop_front();
                    checkOutput("rand32_result", obs32(), exp);
                end
            end
            if (b64.out_valid && b64.out_ready) begin
                checkOutput("rand64_pending", 66'(q64.size() > 0), 66'd1);
                if (q64.size() > 0) begin
                    exp = q64.pop_front();
                    checkOutput("rand64_result", obs64(), exp);
                end
            end

            if (b8.in_valid && b8.in_ready) begin
                q8.push_back(refAdd(8, 64'(ra8), 64'(rb8), rc8));
                sent8++;
            end
            if (b32.in_valid && b32.in_ready) begin
                q32.push_back(refAdd(32, 64'(ra32), 64'(rb32), rc32));
                sent32++;
            end
            if (b64.in_valid && b64.in_ready) begin
                q64.push_back(refAdd(64, ra64, rb64, rc64));
                sent64++;
            end

            @(negedge clk);
            cyc++;
        end
        checkOutput("rand_within_budget", 66'(cyc < MAXCYC), 66'd1);
        checkOutput("rand8_complete",  66'({32'(sent8),  32'(q8.size())}),  66'({32'(NBEATS), 32'd0}));
        checkOutput("rand32_complete", 66'({32'(sent32), 32'(q32.size())}), 66'({32'(NBEATS), 32'd0}));
        checkOutput("rand64_complete", 66'({32'(sent64), 32'(q64.size())}), 66'({32'(NBEATS), 32'd0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
